// File: rtl/output_devices.sv
// Address-selected CPU write port feeding two output devices, each with a holding register,
// a valid/ack handshake and an ack timeout so a dead device cannot stall the CPU.
module output_devices #(
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned AddrWidth  = 16,
  parameter int unsigned AckTimeout = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [AddrWidth-1:0] address_i,
  input  logic [DataWidth-1:0] value_i,
  input  logic                 write_en_i,
  output logic                 write_ready_o,
  output logic                 write_error_o,
  output logic [DataWidth-1:0] device0_values_o,
  output logic                 device0_valid_o,
  input  logic                 device0_ack_i,
  output logic                 device0_timeout_o,
  output logic [DataWidth-1:0] device1_values_o,
  output logic                 device1_valid_o,
  input  logic                 device1_ack_i,
  output logic                 device1_timeout_o
);

  localparam int unsigned NumDev   = 2;
  localparam int unsigned CntWidth = $clog2(AckTimeout + 1);
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(AckTimeout - 1);

  typedef enum logic {StIdle, StPending} dev_state_e;

  dev_state_e          state_q   [NumDev];
  dev_state_e          state_d   [NumDev];
  logic [DataWidth-1:0] values_q [NumDev];
  logic [DataWidth-1:0] values_d [NumDev];
  logic [CntWidth-1:0] cnt_q     [NumDev];
  logic [CntWidth-1:0] cnt_d     [NumDev];
  logic [NumDev-1:0]   timeout_q, timeout_d;
  logic                write_error_q, write_error_d;

  logic [NumDev-1:0] sel;
  logic [NumDev-1:0] valid;
  logic [NumDev-1:0] ack;
  logic [NumDev-1:0] accept;
  logic              mapped;

  assign ack = {device1_ack_i, device0_ack_i};

  always_comb begin
    sel = '0;
    for (int d = 0; d < NumDev; d++) begin
      sel[d] = (address_i == AddrWidth'(d));
    end
    mapped = |sel;
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int d = 0; d < NumDev; d++) begin
        state_q[d]  <= StIdle;
        values_q[d] <= '0;
        cnt_q[d]    <= '0;
      end
      timeout_q     <= '0;
      write_error_q <= 1'b0;
    end else begin
      for (int d = 0; d < NumDev; d++) begin
        state_q[d]  <= state_d[d];
        values_q[d] <= values_d[d];
        cnt_q[d]    <= cnt_d[d];
      end
      timeout_q     <= timeout_d;
      write_error_q <= write_error_d;
    end
  end

  // Next-state logic
  always_comb begin
    accept        = write_en_i ? (sel & ~valid) : '0;
    timeout_d     = timeout_q;
    // Unmapped addresses are always ready, so any write there is an accepted error.
    write_error_d = write_en_i & ~mapped;
    for (int d = 0; d < NumDev; d++) begin
      state_d[d]  = state_q[d];
      values_d[d] = values_q[d];
      cnt_d[d]    = cnt_q[d];
      unique case (state_q[d])
        StIdle: begin
          if (accept[d]) begin
            state_d[d]   = StPending;
            values_d[d]  = value_i;
            cnt_d[d]     = '0;
            timeout_d[d] = 1'b0;
          end
        end
        StPending: begin
          // Ack has priority over an expiring counter.
          if (ack[d]) begin
            state_d[d] = StIdle;
          end else if (cnt_q[d] == CntLast) begin
            state_d[d]   = StIdle;
            timeout_d[d] = 1'b1;
          end else begin
            cnt_d[d] = cnt_q[d] + CntWidth'(1);
          end
        end
      endcase
    end
  end

  // Output logic
  always_comb begin
    valid = '0;
    for (int d = 0; d < NumDev; d++) begin
      valid[d] = (state_q[d] == StPending);
    end
    write_ready_o = mapped ? ~|(sel & valid) : 1'b1;
  end

  assign write_error_o     = write_error_q;
  assign device0_values_o  = values_q[0];
  assign device0_valid_o   = valid[0];
  assign device0_timeout_o = timeout_q[0];
  assign device1_values_o  = values_q[1];
  assign device1_valid_o   = valid[1];
  assign device1_timeout_o = timeout_q[1];

endmodule

// File: tb/tb_output_devices.sv
// Bench for output_devices: directed scenarios plus randomized traffic, all checked against a
// transaction-level model of the two devices (pending flag, data, age since accept, timeout).
module tb_output_devices;

  localparam int T = 4;

  logic        clk;
  logic        rst_n;
  logic [15:0] address;
  logic [31:0] value;
  logic        write_en;
  logic        write_ready;
  logic        write_error;
  logic [31:0] d0_values, d1_values;
  logic        d0_valid, d1_valid;
  logic        d0_ack, d1_ack;
  logic        d0_timeout, d1_timeout;

  int errors = 0;
  int checks = 0;

  logic        m_pend [2];
  logic [31:0] m_data [2];
  int          m_age  [2];
  logic        m_to   [2];
  logic        m_err;

  output_devices #(
    .DataWidth (32),
    .AddrWidth (16),
    .AckTimeout(T)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .address_i        (address),
    .value_i          (value),
    .write_en_i       (write_en),
    .write_ready_o    (write_ready),
    .write_error_o    (write_error),
    .device0_values_o (d0_values),
    .device0_valid_o  (d0_valid),
    .device0_ack_i    (d0_ack),
    .device0_timeout_o(d0_timeout),
    .device1_values_o (d1_values),
    .device1_valid_o  (d1_valid),
    .device1_ack_i    (d1_ack),
    .device1_timeout_o(d1_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_pend[d] = 1'b0;
      m_data[d] = '0;
      m_age[d]  = 0;
      m_to[d]   = 1'b0;
    end
    m_err = 1'b0;
  endfunction

  function automatic logic model_ready();
    if (address < 16'd2) return !m_pend[address];
    return 1'b1;
  endfunction

  // One rising edge worth of device behaviour, from the inputs held across that edge.
  function automatic void model_edge();
    logic rdy;
    logic a [2];
    rdy  = model_ready();
    a[0] = d0_ack;
    a[1] = d1_ack;
    for (int d = 0; d < 2; d++) begin
      if (m_pend[d]) begin
        if (a[d]) begin
          m_pend[d] = 1'b0;
        end else begin
          m_age[d]++;
          if (m_age[d] == T) begin
            m_pend[d] = 1'b0;
            m_to[d]   = 1'b1;
          end
        end
      end else if (write_en && rdy && int'(address) == d) begin
        m_pend[d] = 1'b1;
        m_data[d] = value;
        m_age[d]  = 0;
        m_to[d]   = 1'b0;
      end
    end
    m_err = write_en && (address >= 16'd2);
  endfunction

  task automatic check_all();
    check_eq("d0_values", d0_values, m_data[0]);
    check_eq("d0_valid", {31'd0, d0_valid}, {31'd0, m_pend[0]});
    check_eq("d0_timeout", {31'd0, d0_timeout}, {31'd0, m_to[0]});
    check_eq("d1_values", d1_values, m_data[1]);
    check_eq("d1_valid", {31'd0, d1_valid}, {31'd0, m_pend[1]});
    check_eq("d1_timeout", {31'd0, d1_timeout}, {31'd0, m_to[1]});
    check_eq("write_error", {31'd0, write_error}, {31'd0, m_err});
  endtask

  // Called just after a falling edge: apply inputs, then check the combinational ready.
  task automatic drive(input int addr, input logic [31:0] val, input logic we,
                       input logic a0, input logic a1);
    address  = addr[15:0];
    value    = val;
    write_en = we;
    d0_ack   = a0;
    d1_ack   = a1;
    #1;
    check_eq("write_ready", {31'd0, write_ready}, {31'd0, model_ready()});
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 32'h0, 1'b0, 1'b0, 1'b0);
      tick();
    end
  endtask

  initial begin
    int r;
    int addr;
    rst_n    = 1'b0;
    address  = '0;
    value    = '0;
    write_en = 1'b0;
    d0_ack   = 1'b0;
    d1_ack   = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Basic write to device0
    drive(0, 32'hE5F84AB1, 1'b1, 1'b0, 1'b0);
    tick();
    check_eq("t1_d0_values", d0_values, 32'hE5F84AB1);
    check_eq("t1_d0_valid", {31'd0, d0_valid}, 32'd1);
    check_eq("t1_d1_valid", {31'd0, d1_valid}, 32'd0);

    // Stall while pending, then ack frees the device
    drive(0, 32'h5C8C6A01, 1'b1, 1'b0, 1'b0);
    check_eq("t2_stall_ready", {31'd0, write_ready}, 32'd0);
    tick();
    check_eq("t2_stall_values", d0_values, 32'hE5F84AB1);
    drive(0, 32'h5C8C6A01, 1'b1, 1'b1, 1'b0);
    tick();
    check_eq("t2_ack_valid", {31'd0, d0_valid}, 32'd0);
    drive(0, 32'h5C8C6A01, 1'b1, 1'b0, 1'b0);
    tick();
    check_eq("t2_second_values", d0_values, 32'h5C8C6A01);

    // Device1 independent of pending device0; unmapped write pulses error
    drive(1, 32'h1234ABCD, 1'b1, 1'b0, 1'b0);
    tick();
    check_eq("t3_d1_values", d1_values, 32'h1234ABCD);
    check_eq("t3_d0_still_valid", {31'd0, d0_valid}, 32'd1);
    drive(7, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
    tick();
    check_eq("t3_err_pulse", {31'd0, write_error}, 32'd1);
    drive(7, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
    tick();
    check_eq("t3_err_clear", {31'd0, write_error}, 32'd0);
    idle_cycles(T + 1);

    // Timeout without ack, then the next write clears the flag
    drive(0, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b0);
    tick();
    idle_cycles(T - 1);
    check_eq("t4_valid_before", {31'd0, d0_valid}, 32'd1);
    idle_cycles(1);
    check_eq("t4_valid_after", {31'd0, d0_valid}, 32'd0);
    check_eq("t4_timeout_set", {31'd0, d0_timeout}, 32'd1);
    drive(0, 32'h0F0F0F0F, 1'b1, 1'b0, 1'b0);
    tick();
    check_eq("t4_timeout_clr", {31'd0, d0_timeout}, 32'd0);
    drive(0, 32'h0, 1'b0, 1'b1, 1'b0);
    tick();

    // Ack on the edge that would have timed out
    drive(0, 32'h77778888, 1'b1, 1'b0, 1'b0);
    tick();
    idle_cycles(T - 1);
    drive(0, 32'h0, 1'b0, 1'b1, 1'b0);
    tick();
    check_eq("t5_valid", {31'd0, d0_valid}, 32'd0);
    check_eq("t5_timeout", {31'd0, d0_timeout}, 32'd0);

    // Asynchronous reset in the middle of a pending handshake
    drive(0, 32'hCAFEF00D, 1'b1, 1'b0, 1'b0);
    tick();
    drive(0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check_eq("t6_valid", {31'd0, d0_valid}, 32'd0);
    check_eq("t6_values", d0_values, 32'd0);
    check_eq("t6_timeout", {31'd0, d0_timeout}, 32'd0);
    model_reset();
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_all();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4) addr = 0;
      else if (r < 8) addr = 1;
      else addr = $urandom_range(2, 65535);
      drive(addr, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0,
            $urandom_range(0, 5) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
